// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the single-port RAM burst controller.
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/single_port_ram_ctrl.sv
// Burst initiator for a single-port registered-read RAM: commands in, write
// beats streamed to the RAM, read beats returned over a valid/ready channel.
module single_port_ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk_pi,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              done_o
);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_ready_q, wr_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_last_q, rd_last_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic cmd_hs;
    logic wr_hs;
    logic rd_hs;
    logic last_beat;

    // Handshakes qualify on the registered ready/valid, so ignored inputs
    // outside their state can never trigger anything.
    assign cmd_hs    = cmd_valid_i & cmd_ready_q;
    assign wr_hs     = wr_valid_i & wr_ready_q;
    assign rd_hs     = rd_ready_i & rd_valid_q;
    assign last_beat = (beat_q == len_q);

    // State register
    always_ff @(posedge clk_pi or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (cmd_hs) state_d = cmd_we_i ? WR : RD_ISSUE;
            WR:       if (wr_hs && last_beat) state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = RD_RESP;
            RD_RESP:  if (rd_hs) state_d = last_beat ? IDLE : RD_ISSUE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath logic: every output is the registered image of
    // what the next cycle needs, so it is computed from state_d.
    always_comb begin
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        rd_last_d   = rd_last_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    addr_d = cmd_addr_i;
                    len_d  = cmd_len_i;
                    beat_d = '0;
                    if (!cmd_we_i) begin
                        ram_en_d   = 1'b1;
                        ram_addr_d = cmd_addr_i;
                    end
                end
            end
            WR: begin
                if (wr_hs) begin
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = addr_q;
                    ram_wdata_d = wr_data_i;
                    addr_d      = addr_q + ADDR_W'(1);
                    beat_d      = beat_q + LEN_W'(1);
                    done_d      = last_beat;
                end
            end
            RD_ISSUE: ;
            RD_WAIT: begin
                // Registered-read RAM: dout is valid exactly in this cycle.
                rd_data_d  = ram_rdata_i;
                rd_valid_d = 1'b1;
                rd_last_d  = last_beat;
            end
            RD_RESP: begin
                if (rd_hs) begin
                    rd_valid_d = 1'b0;
                    if (last_beat) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d     = addr_q + ADDR_W'(1);
                        beat_d     = beat_q + LEN_W'(1);
                        ram_en_d   = 1'b1;
                        ram_addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase

        cmd_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WR);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_pi or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_last_q   <= rd_last_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign wr_ready_o  = wr_ready_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign rd_last_o   = rd_last_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
